// File: rtl/syncgen.sv
// ---------------------------------------------------------------------------
// syncgen -- VGA raster timing generator
//
// Counts pixel clocks across each line and lines across each frame.
// From those counts it produces the sync pulses, the visible-area flag and a
// start-of-frame strobe for the renderers and the RGB output register.
// The default parameters give 640x480 @ 60 Hz from a 25 MHz pixel clock.
//
// Every output is a flop. The sync, enable and strobe flops are loaded from
// the *next* counter values, so they always line up with the HCNT/VCNT value
// shown on the same cycle.
//
// Optional build macro:
//   SYNCGEN_FRAME_CNT_EN  adds FRAME_CNT, a free-running 8-bit frame counter
//
// Ports:
//   PCK          in   1   pixel clock, sole clock
//   RST          in   1   asynchronous active-high reset
//   HCNT         out  10  horizontal position, 0..HPERIOD-1
//   VCNT         out  10  vertical position, 0..VPERIOD-1
//   HSYNC        out  1   horizontal sync, active low
//   VSYNC        out  1   vertical sync, active low
//   DISP_EN      out  1   high inside the visible area
//   FRAME_START  out  1   one-cycle pulse when the raster wraps to (0,0)
//   FRAME_CNT    out  8   frame counter (only with SYNCGEN_FRAME_CNT_EN)
// ---------------------------------------------------------------------------
module syncgen #(
  parameter int HPERIOD = 800,
  parameter int HACTIVE = 640,
  parameter int HFRONT  = 16,
  parameter int HWIDTH  = 96,
  parameter int VPERIOD = 525,
  parameter int VACTIVE = 480,
  parameter int VFRONT  = 10,
  parameter int VWIDTH  = 2
) (
  input  logic       PCK,
  input  logic       RST,
  output logic [9:0] HCNT,
  output logic [9:0] VCNT,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DISP_EN,
  output logic       FRAME_START
`ifdef SYNCGEN_FRAME_CNT_EN
  ,
  output logic [7:0] FRAME_CNT
`endif
);

  // The counters are 10 bits wide, so larger timings cannot be represented.
  if (HPERIOD < 1 || HPERIOD > 1024 || VPERIOD < 1 || VPERIOD > 1024 ||
      HACTIVE + HFRONT + HWIDTH > HPERIOD ||
      VACTIVE + VFRONT + VWIDTH > VPERIOD) begin : g_param_check
    $error("syncgen: unsupported timing parameters");
  end

  localparam logic [9:0]  H_LAST   = 10'(HPERIOD - 1);
  localparam logic [9:0]  V_LAST   = 10'(VPERIOD - 1);
  // The thresholds get one extra bit so that an active width of exactly
  // 1024 still compares correctly against a zero-extended counter.
  localparam logic [10:0] H_VIS    = 11'(HACTIVE);
  localparam logic [10:0] V_VIS    = 11'(VACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(HACTIVE + HFRONT);
  localparam logic [10:0] HS_LAST  = 11'(HACTIVE + HFRONT + HWIDTH - 1);
  localparam logic [10:0] VS_FIRST = 11'(VACTIVE + VFRONT);
  localparam logic [10:0] VS_LAST  = 11'(VACTIVE + VFRONT + VWIDTH - 1);

  logic        h_wrap;
  logic        v_wrap;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        hsync_next;
  logic        vsync_next;
  logic        disp_next;
  logic        start_next;

  // Next-state counters and the outputs decoded from them. VCNT only moves
  // when the line wraps, so VSYNC can only change on cycles where HCNT is 0.
  // Reset leaves the counters at (0,0) without a wrap. That is why the
  // first pulse of FRAME_START comes only after a full counted frame.
  always_comb begin
    h_wrap     = (HCNT == H_LAST);
    v_wrap     = (VCNT == V_LAST);
    h_next     = h_wrap ? 10'd0 : HCNT + 10'd1;
    v_next     = VCNT;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : VCNT + 10'd1;
    end
    h_ext      = {1'b0, h_next};
    v_ext      = {1'b0, v_next};
    hsync_next = !((h_ext >= HS_FIRST) && (h_ext <= HS_LAST));
    vsync_next = !((v_ext >= VS_FIRST) && (v_ext <= VS_LAST));
    disp_next  = (h_ext < H_VIS) && (v_ext < V_VIS);
    start_next = h_wrap && v_wrap;
  end

  // Counter and output registers. On reset, the syncs go inactive (high) at
  // once and the raster restarts from (0,0).
  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      HCNT        <= 10'd0;
      VCNT        <= 10'd0;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      DISP_EN     <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      HCNT        <= h_next;
      VCNT        <= v_next;
      HSYNC       <= hsync_next;
      VSYNC       <= vsync_next;
      DISP_EN     <= disp_next;
      FRAME_START <= start_next;
    end
  end

`ifdef SYNCGEN_FRAME_CNT_EN
  // Frame counter: it steps on the same edge that raises FRAME_START and
  // wraps naturally from 255 to 0.
  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      FRAME_CNT <= 8'd0;
    end else if (start_next) begin
      FRAME_CNT <= FRAME_CNT + 8'd1;
    end
  end
`else
  // No frame counter in this build.
`endif

endmodule
